// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//
// Front end for the CPU control FSM's interrupt handling. It synchronises the
// external NMI and IRQ pins, masks IRQ with the I flag of P, runs the
// post-reset CPU hold, and presents a single prioritised request (RESET, NMI
// or IRQ) to the control unit at instruction boundaries. It then tracks that
// request through acknowledge and completion.
//
// Ports:
//   clk            in   system clock, all state updates on posedge
//   rst            in   synchronous active-high reset
//   nmi_n          in   asynchronous NMI pin, active low, edge-triggered
//   irq_n          in   asynchronous IRQ pin, active low, level-sensitive
//   P_in[7:0]      in   processor status register, bit 2 = I (IRQ mask)
//   fetch_strobe   in   one-cycle pulse at the instruction boundary
//   int_ack        in   one-cycle pulse: interrupt sequence entered
//   int_done       in   one-cycle pulse: vector loaded, sequence finished
//   int_req        out  registered request to the control FSM
//   int_src[1:0]   out  00 none, 01 IRQ, 10 NMI, 11 RESET
//   int_vect[15:0] out  vector address for int_src (0 when int_src = 00)
//   brk_flag       out  B value pushed with P; always 0 (hardware source)
//   cpu_hold       out  high while the CPU must stall after reset
//   dbg_state[1:0] out  current FSM state (HOLD=0, IDLE=1, PEND=2, SERVICE=3)
//   dbg_nmi_latch  out  current NMI latch value
//
// Handshake: int_req acts as "valid" for the request described by
// int_src/int_vect. It stays high until the control unit accepts the request
// with int_ack, which plays the role of "ready". The transfer happens on the
// clock edge where int_req=1 and int_ack=1. int_src/int_vect then stay stable
// until int_done closes the sequence. int_ack without int_req is ignored, and
// int_done is only honoured after an accepted request.
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter int          RESET_HOLD  = 6,
    parameter logic [15:0] VEC_NMI     = 16'hFFFA,
    parameter logic [15:0] VEC_RST     = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic [7:0]  P_in,
    input  logic        fetch_strobe,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        int_req,
    output logic [1:0]  int_src,
    output logic [15:0] int_vect,
    output logic        brk_flag,
    output logic        cpu_hold,
    output logic [1:0]  dbg_state,
    output logic        dbg_nmi_latch
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PEND    = 2'd2,
        ST_SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_IRQ  = 2'b01;
    localparam logic [1:0] SRC_NMI  = 2'b10;
    localparam logic [1:0] SRC_RST  = 2'b11;

    localparam int HCW = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);

    function automatic logic [15:0] vec_for(input logic [1:0] src);
        logic [15:0] v;
        case (src)
            SRC_IRQ: v = VEC_IRQ;
            SRC_NMI: v = VEC_NMI;
            SRC_RST: v = VEC_RST;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Pin synchronisers. They reset to 1 (pin inactive) so that releasing
    // reset cannot look like an NMI falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic                   r_nmi_prev;
    logic                   w_nmi_s;
    logic                   w_irq_s;
    logic                   w_nmi_fall;
    logic                   w_irq_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_sync <= '1;
            r_irq_sync <= '1;
            r_nmi_prev <= 1'b1;
        end else begin
            r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
            r_nmi_prev <= w_nmi_s;
        end
    end

    assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
    assign w_nmi_fall = r_nmi_prev & ~w_nmi_s;
    assign w_irq_req  = ~w_irq_s & ~P_in[2];

    // Only the I flag of P matters here.
    logic w_p_unused;
    assign w_p_unused = ^{P_in[7:3], P_in[1:0]};

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [HCW-1:0]  r_hold_cnt;
    logic            r_nmi_latch;
    logic            r_cpu_hold;
    logic            r_int_req;
    logic [1:0]      r_int_src;
    logic [15:0]     r_int_vect;

    state_t          w_state_nxt;
    logic [HCW-1:0]  w_hold_cnt_nxt;
    logic            w_nmi_latch_nxt;
    logic            w_cpu_hold_nxt;
    logic            w_int_req_nxt;
    logic [1:0]      w_int_src_nxt;
    logic            w_latch_set;
    logic            w_latch_clr;

    // NMI edges are not recorded during the reset hold. The latch is cleared
    // when an NMI request is accepted, but a fresh edge arriving in that same
    // cycle must survive, so set has priority over clear.
    assign w_latch_set     = w_nmi_fall & (r_state != ST_HOLD);
    assign w_latch_clr     = (r_state == ST_PEND) & int_ack & (r_int_src == SRC_NMI);
    assign w_nmi_latch_nxt = w_latch_set | (r_nmi_latch & ~w_latch_clr);

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_cpu_hold_nxt = r_cpu_hold;
        w_int_req_nxt  = r_int_req;
        w_int_src_nxt  = r_int_src;

        case (r_state)
            ST_HOLD: begin
                w_cpu_hold_nxt = 1'b1;
                w_int_req_nxt  = 1'b0;
                // The counter is tested at 1 rather than 0 so that cpu_hold
                // drops on the same edge as the counter reaches zero. That
                // gives exactly RESET_HOLD high cycles after rst falls.
                if (r_hold_cnt <= HCW'(1)) begin
                    w_hold_cnt_nxt = '0;
                    w_cpu_hold_nxt = 1'b0;
                    w_state_nxt    = ST_PEND;
                    w_int_req_nxt  = 1'b1;
                    w_int_src_nxt  = SRC_RST;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HCW'(1);
                end
            end
            ST_IDLE: begin
                w_int_req_nxt = 1'b0;
                w_int_src_nxt = SRC_NONE;
                if (fetch_strobe && (r_nmi_latch || w_irq_req)) begin
                    w_state_nxt   = ST_PEND;
                    w_int_req_nxt = 1'b1;
                    w_int_src_nxt = r_nmi_latch ? SRC_NMI : SRC_IRQ;
                end
            end
            ST_PEND: begin
                w_int_req_nxt = 1'b1;
                if (int_ack) begin
                    // A simultaneous int_done is ignored.
                    w_state_nxt   = ST_SERVICE;
                    w_int_req_nxt = 1'b0;
                end else if (r_int_src == SRC_IRQ && r_nmi_latch) begin
                    // The only change allowed while pending: IRQ -> NMI upgrade.
                    w_int_src_nxt = SRC_NMI;
                end
            end
            ST_SERVICE: begin
                w_int_req_nxt = 1'b0;
                if (int_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_int_src_nxt = SRC_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= HCW'(RESET_HOLD);
            r_nmi_latch <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_int_req   <= 1'b0;
            r_int_src   <= SRC_NONE;
            r_int_vect  <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_nmi_latch <= w_nmi_latch_nxt;
            r_cpu_hold  <= w_cpu_hold_nxt;
            r_int_req   <= w_int_req_nxt;
            r_int_src   <= w_int_src_nxt;
            r_int_vect  <= vec_for(w_int_src_nxt);
        end
    end

    assign int_req       = r_int_req;
    assign int_src       = r_int_src;
    assign int_vect      = r_int_vect;
    assign brk_flag      = 1'b0;
    assign cpu_hold      = r_cpu_hold;
    assign dbg_state     = r_state;
    assign dbg_nmi_latch = r_nmi_latch;

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Upstream companion to the CPU control FSM.
- Synchronises the external NMI and IRQ pins and applies IRQ masking from the P register's I flag.
- Sequences the post-reset hold.
- At instruction boundaries, presents one prioritised interrupt request to the control unit, with vector address and B-flag value, and tracks it through acknowledge and completion.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on nmi_n and irq_n (minimum 2).
- RESET_HOLD, 6, cycles cpu_hold stays high after rst deasserts before the RESET request is raised.
- VEC_NMI, 16'hFFFA, NMI vector address.
- VEC_RST, 16'hFFFC, RESET vector address.
- VEC_IRQ, 16'hFFFE, IRQ vector address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- nmi_n  in  1  asynchronous NMI pin, active low, edge-triggered.
- irq_n  in  1  asynchronous IRQ pin, active low, level-sensitive.
- P_in  in  8  processor status register; bit 2 is I (IRQ mask).
- fetch_strobe  in  1  high for the one cycle the control FSM is in its fetch state (instruction boundary).
- int_ack  in  1  one-cycle pulse from control: interrupt sequence entered, vector now being consumed.
- int_done  in  1  one-cycle pulse from control: vector loaded into PC, sequence finished.
- int_req  out  1  registered request to the control FSM.
- int_src  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET.
- int_vect  out  16  vector address for int_src; 16'h0000 when int_src=00.
- brk_flag  out  1  B value the control unit pushes with P; always 0 (hardware source).
- cpu_hold  out  1  high while the CPU must stall during the reset hold.

Behaviour:
- Reset: rst dominates every state, including mid-SERVICE.
  - Reset values: state=HOLD, hold counter=RESET_HOLD, nmi_latch=0, cpu_hold=1, int_req=0, int_src=00, int_vect=0, brk_flag=0.
  - Synchroniser flops reset to 1 (inactive).
- Synchronisers:
  - nmi_s and irq_s are the last stage of SYNC_STAGES-deep chains.
  - nmi_fall = previous nmi_s & ~nmi_s.
  - Pin-to-internal latency: SYNC_STAGES cycles, plus 1 for nmi_fall.
- NMI latch:
  - Set on nmi_fall in any state except HOLD.
  - Cleared on the int_ack cycle when the acknowledged source is NMI.
  - Set wins over clear in the same cycle.
- IRQ active: irq_req = ~irq_s & ~P_in[2], evaluated combinationally each cycle.
- FSM states: HOLD, IDLE, PEND, SERVICE.
  - HOLD: decrement the counter each cycle. When it reaches 0, go to PEND with src=RESET, and cpu_hold falls on the same edge. cpu_hold is high for exactly RESET_HOLD cycles after rst falls. int_ack and int_done are ignored.
  - IDLE: if fetch_strobe=1 and (nmi_latch | irq_req), go to PEND. Latch src using priority NMI > IRQ. Without fetch_strobe, stay in IDLE.
  - PEND: int_req=1. src is frozen except for one upgrade: IRQ is replaced by NMI if nmi_latch sets while pending. IRQ deasserting or I setting does not withdraw a request already in PEND. On int_ack, go to SERVICE (src retained).
  - SERVICE: int_req=0, and int_src/int_vect hold. On int_done, go to IDLE and clear int_src. New NMI edges are latched here and serviced at the next fetch_strobe.
- Output timing: int_req, int_src and int_vect are registered and valid the cycle after the state transition.
- Spurious handshakes:
  - int_ack outside PEND is ignored.
  - int_done outside SERVICE is ignored.
  - int_ack and int_done high together in PEND: only ack is acted on.
- brk_flag is constant 0. Software BRK is handled inside control, not here.

Test Plan:
- Reset release: rst high 3 cycles, then low.
  - cpu_hold=1 for exactly 6 cycles after rst falls.
  - Next cycle: int_req=1, int_src=11, int_vect=FFFC.
  - Pulse int_ack, then int_done: int_req falls after ack; int_src=00 after done.
- IRQ masked/unmasked: irq_n low, P_in=8'h04, fetch_strobe pulses → no int_req. Change P_in to 8'h00 with a fetch_strobe → int_req=1, int_src=01, int_vect=FFFE, brk_flag=0.
- NMI edge: nmi_n 1→0, held low 20 cycles, one full ack/done sequence → exactly one request (src=10, vect=FFFA). No second request while nmi_n stays low.
- Priority and upgrade:
  - irq_n low and NMI edge before the same fetch_strobe → src=10.
  - Separately, IRQ in PEND, then NMI edge before ack → int_src changes to 10, and after ack nmi_latch is clear.
- NMI during SERVICE: NMI edge between ack and done → after done, the next fetch_strobe raises int_req with src=10.
- Reset mid-SERVICE: assert rst while in SERVICE → int_req=0, cpu_hold=1, nmi_latch=0 the next cycle. The hold sequence restarts from 6.
